// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - two-requester round-robin arbiter driving a single APB master port

module apb_req_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [1:0]          req,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [1:0]          req_write,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          done,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_slverr,
    output logic                timeout,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [ADDR_W-1:0]   paddr,
    output logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pready,
    input  logic                pslverr
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t              state, state_n;
    logic                grant, grant_n;
    logic                last_grant, last_grant_n;
    logic [CW-1:0]       wait_cnt, wait_cnt_n;
    logic                psel_n, penable_n, pwrite_n;
    logic [ADDR_W-1:0]   paddr_n;
    logic [DATA_W-1:0]   pwdata_n;
    logic [1:0]          done_n;
    logic [DATA_W-1:0]   rsp_rdata_n;
    logic                rsp_slverr_n, timeout_n;
    logic [1:0]          elig;
    logic                win;
    logic                timeout_hit;

    // A requester completing this cycle still shows its stale req; mask it out.
    assign elig = req & ~done;
    assign win  = (elig == 2'b11) ? ~last_grant : elig[1];

    // Fires in the ACCESS cycle that would be the TIMEOUT-th one without pready.
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        state_n      = state;
        grant_n      = grant;
        last_grant_n = last_grant;
        wait_cnt_n   = wait_cnt;
        psel_n       = psel;
        penable_n    = penable;
        pwrite_n     = pwrite;
        paddr_n      = paddr;
        pwdata_n     = pwdata;
        done_n       = 2'b00;
        rsp_rdata_n  = '0;
        rsp_slverr_n = 1'b0;
        timeout_n    = 1'b0;
        case (state)
            IDLE: begin
                if (|elig) begin
                    grant_n      = win;
                    last_grant_n = win;
                    paddr_n      = win ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
                    pwdata_n     = win ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
                    pwrite_n     = req_write[win];
                    psel_n       = 1'b1;
                    penable_n    = 1'b0;
                    wait_cnt_n   = '0;
                    state_n      = SETUP;
                end
            end
            SETUP: begin
                penable_n = 1'b1;
                state_n   = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    state_n      = IDLE;
                    psel_n       = 1'b0;
                    penable_n    = 1'b0;
                    done_n       = grant ? 2'b10 : 2'b01;
                    rsp_rdata_n  = pwrite ? '0 : prdata;
                    rsp_slverr_n = pslverr;
                end else if (timeout_hit) begin
                    state_n      = IDLE;
                    psel_n       = 1'b0;
                    penable_n    = 1'b0;
                    done_n       = grant ? 2'b10 : 2'b01;
                    rsp_slverr_n = 1'b1;
                    timeout_n    = 1'b1;
                end else if (wait_cnt != '1) begin
                    wait_cnt_n = wait_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            wait_cnt   <= '0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= '0;
            pwdata     <= '0;
            done       <= 2'b00;
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            last_grant <= last_grant_n;
            wait_cnt   <= wait_cnt_n;
            psel       <= psel_n;
            penable    <= penable_n;
            pwrite     <= pwrite_n;
            paddr      <= paddr_n;
            pwdata     <= pwdata_n;
            done       <= done_n;
            rsp_rdata  <= rsp_rdata_n;
            rsp_slverr <= rsp_slverr_n;
            timeout    <= timeout_n;
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb/tb_apb_req_arbiter.sv - scoreboard bench for apb_req_arbiter

module tb_apb_req_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  req, req_write;
    logic [63:0] req_addr, req_wdata;
    logic [1:0]  done;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr, timeout, psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready, pslverr;

    always #5 clk = ~clk;

    apb_req_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .resetn(resetn), .req(req), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .done(done),
        .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr), .timeout(timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    typedef struct packed {
        logic [1:0]  done;
        logic [31:0] rdata;
        logic        slverr;
        logic        tmo;
    } cpl_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
    } setup_t;

    cpl_t   exp_cpl[$];
    setup_t exp_setup[$];
    int     total  = 0;
    int     passed = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    task automatic push_cpl(input logic [1:0] d, input logic [31:0] rd, input logic err, input logic tmo);
        cpl_t c;
        c.done = d; c.rdata = rd; c.slverr = err; c.tmo = tmo;
        exp_cpl.push_back(c);
    endtask

    task automatic push_setup(input logic [31:0] a, input logic w, input logic [31:0] wd);
        setup_t s;
        s.addr = a; s.write = w; s.wdata = wd;
        exp_setup.push_back(s);
    endtask

    // APB slave: pready after slv_wait low ACCESS cycles; slv_wait < 0 never answers.
    int          slv_wait  = 0;
    logic        slv_err   = 1'b0;
    logic [31:0] slv_rdata = '0;
    int          acc_n     = 0;

    always @(negedge clk) begin
        if (psel && penable) acc_n++;
        else acc_n = 0;
        pready  = psel && penable && (slv_wait >= 0) && (acc_n > slv_wait);
        prdata  = slv_rdata;
        pslverr = pready ? slv_err : 1'b0;
    end

    always @(negedge clk) begin : monitor
        setup_t s;
        cpl_t   c;
        if (psel && !penable) begin
            if (exp_setup.size() == 0) check("unexpected_setup", {32'd0, paddr}, 64'hffff_ffff);
            else begin
                s = exp_setup.pop_front();
                check("setup_paddr", paddr, s.addr);
                check("setup_pwrite", pwrite, s.write);
                if (s.write) check("setup_pwdata", pwdata, s.wdata);
            end
        end
        if (done != 2'b00) begin
            if (exp_cpl.size() == 0) check("unexpected_done", done, 2'b00);
            else begin
                c = exp_cpl.pop_front();
                check("done", done, c.done);
                check("rsp_rdata", rsp_rdata, c.rdata);
                check("rsp_slverr", rsp_slverr, c.slverr);
                check("timeout", timeout, c.tmo);
            end
        end else begin
            check("quiet_rsp", {timeout, rsp_slverr, rsp_rdata}, 64'd0);
        end
    end

    // Runs one transfer already queued; returns ACCESS cycle count, drops req on done.
    task automatic run_xfer(input string name, output int acc);
        int n;
        acc = 0;
        n   = 0;
        while (done == 2'b00 && n < 40) begin
            @(negedge clk);
            n++;
            if (psel && penable) acc++;
        end
        check({name, "_done_seen"}, (done != 2'b00), 1'b1);
        req = 2'b00;
        check({name, "_psel_low_at_done"}, psel, 1'b0);
    endtask

    initial begin
        int acc, k, cyc;
        int times[4];
        resetn = 1'b1; req = 2'b00; req_write = 2'b00; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_psel_penable_pwrite", {psel, penable, pwrite}, 3'b000);
        check("rst_paddr_pwdata", {paddr, pwdata}, 64'd0);
        check("rst_done_timeout", {done, timeout, rsp_slverr}, 4'd0);
        resetn = 1'b0;
        @(negedge clk);

        // single read, minimum latency
        slv_wait = 0; slv_err = 1'b0; slv_rdata = 32'hA5A5_0001;
        req_addr[31:0] = 32'h10;
        push_setup(32'h10, 1'b0, 32'h0);
        push_cpl(2'b01, 32'hA5A5_0001, 1'b0, 1'b0);
        req = 2'b01;
        @(negedge clk);
        check("read_c1_psel_penable", {psel, penable}, 2'b10);
        @(negedge clk);
        check("read_c2_psel_penable", {psel, penable}, 2'b11);
        @(negedge clk);
        req = 2'b00;
        check("read_c3_done", done, 2'b01);
        check("read_c3_psel_penable", {psel, penable}, 2'b00);
        repeat (2) @(negedge clk);

        // contention from reset: 0,1,0,1 at 3-cycle spacing
        resetn = 1'b1;
        @(negedge clk);
        resetn = 1'b0;
        req_write = 2'b11;
        req_addr  = {32'h200, 32'h100};
        req_wdata = {32'h2222_2222, 32'h1111_1111};
        for (int i = 0; i < 2; i++) begin
            push_setup(32'h100, 1'b1, 32'h1111_1111);
            push_setup(32'h200, 1'b1, 32'h2222_2222);
            push_cpl(2'b01, 32'h0, 1'b0, 1'b0);
            push_cpl(2'b10, 32'h0, 1'b0, 1'b0);
        end
        req = 2'b11;
        k = 0; cyc = 0;
        while (k < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done != 2'b00) begin
                times[k] = cyc;
                k++;
                if (k == 4) req = 2'b00;
            end
        end
        check("cont_count", k, 4);
        check("cont_first_latency", times[0], 3);
        for (int i = 1; i < 4; i++) check("cont_spacing", times[i] - times[i-1], 3);
        repeat (2) @(negedge clk);

        // write on requester 1, 3 wait states, slave error
        slv_wait = 3; slv_err = 1'b1;
        req_write = 2'b10;
        req_addr[63:32]  = 32'h300;
        req_wdata[63:32] = 32'hDEAD_BEEF;
        push_setup(32'h300, 1'b1, 32'hDEAD_BEEF);
        push_cpl(2'b10, 32'h0, 1'b1, 1'b0);
        req = 2'b10;
        run_xfer("wr_wait", acc);
        check("wr_wait_access_len", acc, 4);
        repeat (2) @(negedge clk);

        // timeout with pready held low
        slv_wait = -1; slv_err = 1'b0; slv_rdata = 32'h0000_0077;
        req_write = 2'b00;
        req_addr[31:0] = 32'h400;
        push_setup(32'h400, 1'b0, 32'h0);
        push_cpl(2'b01, 32'h0, 1'b1, 1'b1);
        req = 2'b01;
        run_xfer("tmo", acc);
        check("tmo_access_len", acc, 4);
        repeat (2) @(negedge clk);

        // pready arrives in the timeout cycle: normal completion
        slv_wait = 3; slv_rdata = 32'h1234_5678;
        req_addr[63:32] = 32'h500;
        push_setup(32'h500, 1'b0, 32'h0);
        push_cpl(2'b10, 32'h1234_5678, 1'b0, 1'b0);
        req = 2'b10;
        run_xfer("edge_tmo", acc);
        check("edge_tmo_access_len", acc, 4);
        repeat (2) @(negedge clk);

        // reset in the middle of ACCESS abandons the transfer
        slv_wait = -1;
        req_addr[31:0] = 32'h600;
        push_setup(32'h600, 1'b0, 32'h0);
        req = 2'b01;
        k = 0;
        while (!(psel && penable) && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("rstmid_reached_access", {psel, penable}, 2'b11);
        resetn = 1'b1;
        req = 2'b00;
        @(negedge clk);
        check("rstmid_apb_zero", {psel, penable, pwrite, paddr, pwdata[15:0]}, 64'd0);
        check("rstmid_rsp_zero", {done, timeout, rsp_slverr, rsp_rdata}, 64'd0);
        resetn = 1'b0;
        slv_wait = 0; slv_rdata = 32'h0000_CAFE;
        req_addr = {32'h800, 32'h700};
        push_setup(32'h700, 1'b0, 32'h0);
        push_cpl(2'b01, 32'h0000_CAFE, 1'b0, 1'b0);
        req = 2'b11;
        run_xfer("post_rst", acc);
        repeat (5) @(negedge clk);

        check("cpl_queue_drained", exp_cpl.size(), 0);
        check("setup_queue_drained", exp_setup.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1);
    end

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 32, APB address width; DATA_W, default 32, APB data width; TIMEOUT, default 16, maximum ACCESS cycles without pready (0 = timeout disabled).
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  input  1  single clock; all logic on rising edge.
- resetn  input  1  synchronous, active-high reset.
- req  input  2  per-requester transfer request; bit i = requester i.
- req_addr  input  2*ADDR_W  packed {addr1, addr0}.
- req_write  input  2  1 = write, 0 = read.
- req_wdata  input  2*DATA_W  packed {wdata1, wdata0}.
- done  output  2  one-cycle completion pulse; at most one bit set.
- rsp_rdata  output  DATA_W  read data, valid while done != 0.
- rsp_slverr  output  1  error status, valid while done != 0.
- timeout  output  1  one-cycle pulse; completion was forced by timeout.
- psel, penable, pwrite  output  1 each  APB master controls.
- paddr  output  ADDR_W  APB address.
- pwdata  output  DATA_W  APB write data.
- prdata  input  DATA_W  APB read data.
- pready  input  1  APB ready.
- pslverr  input  1  APB slave error.
REQ-003 SHALL drive all outputs from registers.

Function
REQ-004 SHALL implement the FSM states IDLE, SETUP and ACCESS.
REQ-005 IDLE: if any eligible req is set, SHALL select a winner, latch its addr, write and wdata into paddr, pwrite and pwdata, and go to SETUP next cycle. Otherwise SHALL stay in IDLE.
REQ-006 Arbitration SHALL be round-robin using a last-grant pointer:
- both eligible: grant the requester not granted last;
- one eligible: grant that requester;
- after reset, requester 0 wins the first tie.
REQ-007 A requester i whose done[i]=1 in the current cycle SHALL be ineligible in that cycle, so a stale req is never re-granted.
REQ-008 SETUP SHALL last exactly 1 cycle with psel=1, penable=0, then go to ACCESS.
REQ-009 ACCESS SHALL drive psel=1 and penable=1. paddr, pwrite and pwdata SHALL stay stable from SETUP through the end of ACCESS.
REQ-010 In ACCESS with pready=1, the next cycle SHALL have:
- state IDLE, psel=0, penable=0;
- done[g]=1 for the granted requester g;
- rsp_rdata = prdata sampled at completion (0 for writes);
- rsp_slverr = pslverr sampled at completion.
REQ-011 Minimum latency SHALL be: req seen in IDLE at cycle 0 -> SETUP cycle 1 -> ACCESS cycle 2 -> done at cycle 3 when pready=1 in cycle 2. Back-to-back transfers therefore take 3 cycles each.
REQ-012 An ACCESS wait counter SHALL count cycles with pready=0. If TIMEOUT != 0 and the counter reaches TIMEOUT, the next cycle SHALL have: psel=0, penable=0, state IDLE, done[g]=1, rsp_slverr=1, timeout=1, rsp_rdata=0.
REQ-013 The wait counter SHALL clear on entry to SETUP and SHALL be wide enough to hold TIMEOUT without wrap.
REQ-014 If pready=1 arrives in the same cycle the counter reaches TIMEOUT, the transfer SHALL complete normally (REQ-010) with timeout=0.
REQ-015 Requesters SHALL hold req and their fields stable until done. Deasserting req mid-transfer SHALL NOT abort the transfer; done SHALL still pulse.
REQ-016 done, timeout, rsp_rdata and rsp_slverr SHALL be 0 in every cycle where no completion is reported.

Reset
REQ-017 resetn=1 sampled on a clock edge SHALL set on the next cycle:
- state IDLE;
- psel, penable, pwrite = 0; paddr, pwdata = 0;
- done, timeout, rsp_rdata, rsp_slverr = 0;
- wait counter = 0;
- last-grant pointer = 1, so requester 0 wins the next tie.
REQ-018 Reset mid-transfer SHALL abandon the transfer with no done pulse. Arbitration SHALL restart from IDLE after resetn=0.

Verification
REQ-019 Single read: req=01, addr0=0x10, pready=1 in first ACCESS with prdata=0xA5A5_0001 -> psel high cycles 1-2, penable high cycle 2 only, done=01 in cycle 3, rsp_rdata=0xA5A5_0001, rsp_slverr=0.
REQ-020 Contention: req=11 held for 4 transfers -> grant order 0,1,0,1; no IDLE cycle longer than 1 between transfers; paddr matches each winner.
REQ-021 Wait states and error: write on requester 1 with pready low for 3 ACCESS cycles, then pready=1 and pslverr=1 -> ACCESS lasts 4 cycles, done=10, rsp_slverr=1, timeout=0.
REQ-022 Timeout: TIMEOUT=4, pready held 0 -> after 4 ACCESS cycles psel=0, done pulse, rsp_slverr=1, timeout=1. A second case with pready=1 in the TIMEOUT cycle -> normal completion with timeout=0.
REQ-023 Reset mid-ACCESS: resetn=1 for one cycle during ACCESS -> next cycle all outputs 0 and no done. With req=11 after release -> requester 0 granted first.
